// File: rtl/inst_compress_queue.sv
// inst_compress_queue: two-in/two-out compressing instruction queue between fetch and decode.
// Ports:
//   clk, rst_n              - clock and asynchronous active-low reset
//   flush_i                 - synchronous flush, wins over any read or write
//   write_valid_i/_ready_o  - write handshake; ready needs two free entries
//   write_num_i             - lanes to enqueue (0..2), lane 0 older
//   write_data_i            - two write lanes
//   read_valid_o            - bit i set when entry head+i is valid
//   read_ready_i/read_num_i - dequeue 0..2 entries, clamped to occupancy
//   read_data_o             - entries at head and head+1
module inst_compress_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       write_valid_i,
  output logic                       write_ready_o,
  input  logic [1:0]                 write_num_i,
  input  logic [1:0][DATA_WIDTH-1:0] write_data_i,
  output logic [1:0]                 read_valid_o,
  input  logic                       read_ready_i,
  input  logic [1:0]                 read_num_i,
  output logic [1:0][DATA_WIDTH-1:0] read_data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] TWO_C = (AW+1)'(2);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1, wr_ptr1;
  logic [AW:0] count_q, count_d, rd_req;
  logic [1:0] wr_n, rd_n;
  assign write_ready_o = (DEPTH_C - count_q) >= TWO_C;
  assign read_valid_o = {count_q >= TWO_C, count_q != '0};
  assign rd_ptr1 = rd_ptr_q + AW'(1);
  assign wr_ptr1 = wr_ptr_q + AW'(1);
  assign read_data_o[0] = mem_q[rd_ptr_q];
  assign read_data_o[1] = mem_q[rd_ptr1];
  // write_num_i==3 is illegal and treated as no write
  assign wr_n = (write_valid_i && write_ready_o && write_num_i != 2'd3) ? write_num_i : 2'd0;
  // read_num_i==3 behaves as 2, then clamp to occupancy (count < 2 here so low bits suffice)
  assign rd_req = (AW+1)'((read_num_i == 2'd3) ? 2'd2 : read_num_i);
  assign rd_n = !read_ready_i ? 2'd0 : (rd_req > count_q) ? count_q[1:0] : rd_req[1:0];
  always_comb begin
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(rd_n);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(wr_n);
    count_d  = flush_i ? '0 : count_q + (AW+1)'(wr_n) - (AW+1)'(rd_n);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (!flush_i && wr_n != 2'd0) mem_q[wr_ptr_q] <= write_data_i[0];
    if (!flush_i && wr_n == 2'd2) mem_q[wr_ptr1] <= write_data_i[1];
  end
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= DEPTH_C) else $error("queue count overflow");
      assert (!write_valid_i || write_num_i != 2'd3) else $error("write_num_i of 3");
      assert (!read_ready_i || 32'(read_num_i) <= $countones(read_valid_o))
        else $warning("read request exceeds valid entries, clamped");
    end
  end
endmodule

// File: tb/tb_inst_compress_queue.sv
// tb_inst_compress_queue: scoreboard bench for inst_compress_queue.
module tb_inst_compress_queue;
  logic clk, rst_n, flush_i, write_valid_i, write_ready_o, read_ready_i;
  logic [1:0] write_num_i, read_valid_o, read_num_i;
  logic [1:0][15:0] write_data_i, read_data_o;
  logic [15:0] sb [$];
  int total, bad;
  inst_compress_queue #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
    .write_num_i(write_num_i), .write_data_i(write_data_i),
    .read_valid_o(read_valid_o), .read_ready_i(read_ready_i),
    .read_num_i(read_num_i), .read_data_o(read_data_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic idle();
    write_valid_i = 0; write_num_i = 0; write_data_i = '0;
    read_ready_i = 0; read_num_i = 0; flush_i = 0;
  endtask
  task automatic step(input logic wv, input logic [1:0] wn, input logic [15:0] d0, input logic [15:0] d1,
                      input logic rr, input logic [1:0] rn, input logic fl);
    int sz, nr;
    logic rdy;
    write_valid_i = wv; write_num_i = wn; write_data_i[0] = d0; write_data_i[1] = d1;
    read_ready_i = rr; read_num_i = rn; flush_i = fl;
    sz = sb.size();
    rdy = (8 - sz) >= 2;
    nr = rr ? ((rn == 2'd3) ? 2 : int'(rn)) : 0;
    if (nr > sz) nr = sz;
    @(posedge clk); #1;
    if (fl) sb.delete();
    else begin
      for (int i = 0; i < nr; i++) void'(sb.pop_front());
      if (wv && rdy && wn != 2'd3) begin
        sb.push_back(d0);
        if (wn == 2'd2) sb.push_back(d1);
      end
    end
    idle();
  endtask
  task automatic test_reset();
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", read_valid_o); end
    total++; if (write_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", write_ready_o); end
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < 3; i++) step(1, 2, 16'(2*i), 16'(2*i+1), 0, 0, 0);
    total++; if (write_ready_o !== 1'b1) begin bad++; $display("FAIL fill6_ready got=%b want=1", write_ready_o); end
    total++; if (read_valid_o !== 2'b11) begin bad++; $display("FAIL fill6_valid got=%b want=11", read_valid_o); end
    step(1, 1, 16'd6, 16'hDEAD, 0, 0, 0);
    total++; if (write_ready_o !== 1'b0) begin bad++; $display("FAIL fill7_ready got=%b want=0", write_ready_o); end
    for (int k = 0; k < 4; k++) begin
      total++; if (read_data_o[0] !== 16'(2*k)) begin bad++; $display("FAIL drain_l0 got=%h want=%h", read_data_o[0], 16'(2*k)); end
      if (k < 3) begin
        total++; if (read_valid_o !== 2'b11) begin bad++; $display("FAIL drain_valid got=%b want=11", read_valid_o); end
        total++; if (read_data_o[1] !== 16'(2*k+1)) begin bad++; $display("FAIL drain_l1 got=%h want=%h", read_data_o[1], 16'(2*k+1)); end
      end else begin
        total++; if (read_valid_o !== 2'b01) begin bad++; $display("FAIL drain_last_valid got=%b want=01", read_valid_o); end
      end
      step(0, 0, 0, 0, 1, 2, 0);
    end
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL drain_empty got=%b want=00", read_valid_o); end
  endtask
  task automatic test_wrap();
    logic [15:0] tag;
    tag = 16'h0100;
    for (int i = 0; i < 40; i++) begin
      total++; if (write_ready_o !== ((8 - sb.size()) >= 2)) begin bad++; $display("FAIL wrap_ready got=%b size=%0d", write_ready_o, sb.size()); end
      if (sb.size() > 0) begin
        total++; if (read_valid_o[0] !== 1'b1 || read_data_o[0] !== sb[0]) begin bad++; $display("FAIL wrap_order got=%h want=%h", read_data_o[0], sb[0]); end
      end
      if (i % 2 == 0) begin
        step(1, 1, tag, 16'hDEAD, sb.size() > 0, 1, 0);
        tag = tag + 1;
      end else begin
        step(1, 2, tag, tag + 1, sb.size() > 0, 1, 0);
        tag = tag + 2;
      end
    end
    for (int g = 0; g < 10 && sb.size() > 0; g++) begin
      total++; if (read_data_o[0] !== sb[0]) begin bad++; $display("FAIL wrap_tail got=%h want=%h", read_data_o[0], sb[0]); end
      step(0, 0, 0, 0, 1, 1, 0);
    end
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL wrap_empty got=%b want=00", read_valid_o); end
  endtask
  task automatic test_simultaneous();
    int n;
    for (int i = 0; i < 3; i++) step(1, 2, 16'h0200 + 16'(2*i), 16'h0201 + 16'(2*i), 0, 0, 0);
    total++; if (write_ready_o !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b want=1", write_ready_o); end
    step(1, 2, 16'h0206, 16'h0207, 1, 2, 0);
    total++; if (read_data_o[0] !== 16'h0202 || read_data_o[1] !== 16'h0203) begin bad++; $display("FAIL simul_head got=%h/%h want=0202/0203", read_data_o[0], read_data_o[1]); end
    n = 0;
    for (int g = 0; g < 10 && read_valid_o[0]; g++) begin
      total++; if (read_data_o[0] !== sb[0]) begin bad++; $display("FAIL simul_order got=%h want=%h", read_data_o[0], sb[0]); end
      step(0, 0, 0, 0, 1, 1, 0);
      n++;
    end
    total++; if (n != 6) begin bad++; $display("FAIL simul_count got=%0d want=6", n); end
  endtask
  task automatic test_overread();
    step(1, 1, 16'h0300, 16'hDEAD, 0, 0, 0);
    total++; if (read_valid_o !== 2'b01 || read_data_o[0] !== 16'h0300) begin bad++; $display("FAIL over_pre got=%b/%h want=01/0300", read_valid_o, read_data_o[0]); end
    step(0, 0, 0, 0, 1, 2, 0);
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL over_valid got=%b want=00", read_valid_o); end
    step(0, 0, 0, 0, 1, 1, 0);
    step(1, 2, 16'h0301, 16'h0302, 0, 0, 0);
    total++; if (read_valid_o !== 2'b11 || read_data_o[0] !== 16'h0301 || read_data_o[1] !== 16'h0302) begin bad++; $display("FAIL over_after got=%b/%h/%h want=11/0301/0302", read_valid_o, read_data_o[0], read_data_o[1]); end
    step(0, 0, 0, 0, 1, 2, 0);
  endtask
  task automatic test_flush();
    step(1, 2, 16'h0400, 16'h0401, 0, 0, 0);
    step(1, 2, 16'h0402, 16'h0403, 0, 0, 0);
    step(1, 1, 16'h0404, 16'hDEAD, 0, 0, 0);
    step(1, 2, 16'h0405, 16'h0406, 1, 2, 1);
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b want=00", read_valid_o); end
    total++; if (write_ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", write_ready_o); end
    step(1, 1, 16'h00AA, 16'hDEAD, 0, 0, 0);
    total++; if (read_valid_o !== 2'b01 || read_data_o[0] !== 16'h00AA) begin bad++; $display("FAIL flush_tagA got=%b/%h want=01/00aa", read_valid_o, read_data_o[0]); end
    step(0, 0, 0, 0, 1, 1, 0);
  endtask
  task automatic test_async_reset();
    step(1, 2, 16'h0500, 16'h0501, 0, 0, 0);
    step(1, 2, 16'h0502, 16'h0503, 0, 0, 0);
    total++; if (read_valid_o !== 2'b11) begin bad++; $display("FAIL arst_pre got=%b want=11", read_valid_o); end
    #2 rst_n = 0;
    #1;
    total++; if (read_valid_o !== 2'b00) begin bad++; $display("FAIL arst_valid got=%b want=00", read_valid_o); end
    total++; if (write_ready_o !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", write_ready_o); end
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    step(1, 2, 16'h00BB, 16'h00BC, 0, 0, 0);
    total++; if (read_data_o[0] !== 16'h00BB || read_data_o[1] !== 16'h00BC) begin bad++; $display("FAIL arst_tagB got=%h/%h want=00bb/00bc", read_data_o[0], read_data_o[1]); end
    total++; if (read_data_o[0] !== sb[0]) begin bad++; $display("FAIL arst_sb got=%h want=%h", read_data_o[0], sb[0]); end
  endtask
  initial begin
    total = 0; bad = 0;
    idle();
    rst_n = 0;
    #12;
    test_reset();
    @(posedge clk); #1 rst_n = 1;
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_overread();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
